// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - iterative 16-bit unsigned multiply/divide sequencer driving a shared ALU
//
// Purpose:
//   Runs MUL (shift-and-add) and DIV/REM (restoring subtract) as a 16-iteration
//   loop. Each iteration borrows the external combinational ALU. The sequencer
//   drives the operands and operation code, then consumes the sum and carry-out.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   request pulse, accepted whenever busy=0 (IDLE or DONE)
//   op          in   0 = multiply, 1 = divide
//   opa         in   multiplicand / dividend
//   opb         in   multiplier / divisor
//   busy        out  high while iterating
//   done        out  one-cycle completion pulse
//   err         out  divide-by-zero flag, held until the next accepted start
//   res_hi      out  product high half / remainder
//   res_lo      out  product low half / quotient
//   alu_a       out  ALU operand A
//   alu_b       out  ALU operand B
//   alu_oper    out  ALU operation (0000 = A+B, 0001 = A-B)
//   alu_result  in   ALU result
//   alu_co      in   ALU carry-out (for subtract: 1 means A >= B)

module alu_muldiv_seq #(
  parameter int OPERAND_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     op,
  input  logic [OPERAND_WIDTH-1:0] opa,
  input  logic [OPERAND_WIDTH-1:0] opb,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [OPERAND_WIDTH-1:0] res_hi,
  output logic [OPERAND_WIDTH-1:0] res_lo,
  output logic [OPERAND_WIDTH-1:0] alu_a,
  output logic [OPERAND_WIDTH-1:0] alu_b,
  output logic [3:0]               alu_oper,
  input  logic [OPERAND_WIDTH-1:0] alu_result,
  input  logic                     alu_co
);

  localparam int W  = OPERAND_WIDTH;
  localparam int CW = $clog2(OPERAND_WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OPER_ADD = 4'b0000;
  localparam logic [3:0] OPER_SUB = 4'b0001;

  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  // The working registers are shared by both operations:
  //   hi_q   : PH (multiply) / R partial remainder (divide)
  //   lo_q   : PL multiplier shifting out / Q dividend shifting into quotient
  //   opnd_q : M multiplicand / D divisor
  logic [1:0]    state_q, state_d;
  logic          op_q, op_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  opnd_q, opnd_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  res_hi_q, res_hi_d;
  logic [W-1:0]  res_lo_q, res_lo_d;
  logic          err_q, err_d;

  logic [W-1:0]  hi_next;
  logic [W-1:0]  lo_next;
  logic          ge;
  logic          accept;

  // ALU drive: quiet (zeros, ADD) everywhere except RUN.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_oper = OPER_ADD;
    if (state_q == ST_RUN) begin
      if (!op_q) begin
        alu_a = hi_q;
        alu_b = lo_q[0] ? opnd_q : '0;
      end else begin
        alu_oper = OPER_SUB;
        alu_a    = {hi_q[W-2:0], lo_q[W-1]};
        alu_b    = opnd_q;
      end
    end
  end

  // One iteration's update, computed from the ALU answer.
  // For divide, a set R[15] means the shifted partial remainder is 17 bits wide.
  // It must then exceed any 16-bit divisor, and the 16-bit difference is exact.
  always_comb begin
    ge = hi_q[W-1] | alu_co;
    if (!op_q) begin
      hi_next = {alu_co, alu_result[W-1:1]};
      lo_next = {alu_result[0], lo_q[W-1:1]};
    end else begin
      hi_next = ge ? alu_result : alu_a;
      lo_next = {lo_q[W-2:0], ge};
    end
  end

  assign accept = start && (state_q != ST_RUN);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    count_d  = count_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          op_d    = op;
          count_d = '0;
          err_d   = 1'b0;
          if (op && (opb == '0)) begin
            // Divide-by-zero completes without iterating.
            state_d  = ST_DONE;
            err_d    = 1'b1;
            res_hi_d = opa;
            res_lo_d = '1;
            hi_d     = '0;
            lo_d     = '0;
            opnd_d   = '0;
          end else begin
            state_d = ST_RUN;
            hi_d    = '0;
            lo_d    = op ? opa : opb;
            opnd_d  = op ? opb : opa;
          end
        end
      end

      ST_RUN: begin
        hi_d    = hi_next;
        lo_d    = lo_next;
        count_d = count_q + 1'b1;
        if (count_q == LAST_ITER) begin
          state_d  = ST_DONE;
          res_hi_d = hi_next;
          res_lo_d = lo_next;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      count_q  <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      count_q  <= count_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign err    = err_q;
  assign res_hi = res_hi_q;
  assign res_lo = res_lo_q;

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Iterative 16-bit unsigned multiply/divide sequencer that acts as the initiator on the shared ALU operand/result interface: it drives operand A, operand B and the 4-bit operation code each cycle, and consumes the combinational sum and carry-out. It sits beside the ALU in the execute stage and implements MUL and DIV/REM as a 16-iteration shift-and-add / restoring-subtract loop, with a start/busy/done handshake toward the decode/control logic.

## Interface
- OPERAND_WIDTH, 16, data width; only 16 is supported, matching the 16-bit ALU.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only when busy=0.
- op  in  1  0 = multiply, 1 = divide.
- opa  in  16  multiplicand / dividend, latched at start.
- opb  in  16  multiplier / divisor, latched at start.
- busy  out  1  high while iterating.
- done  out  1  one-cycle completion pulse.
- err  out  1  divide-by-zero flag, valid with done, held until next start.
- res_hi  out  16  product high half / remainder.
- res_lo  out  16  product low half / quotient.
- alu_a  out  16  ALU operand A.
- alu_b  out  16  ALU operand B.
- alu_oper  out  4  ALU operation: 4'b0000 = A+B, 4'b0001 = A-B (A + ~B + 1).
- alu_result  in  16  ALU result, combinational from alu_a/alu_b/alu_oper.
- alu_co  in  1  ALU carry-out; for subtract, 1 means A >= B unsigned.

## Operation
- States: IDLE, RUN, DONE. busy = (state == RUN).
- IDLE: start=1 latches op/opa/opb; count <= 0. If op=1 and opb=0 -> DONE directly with err=1, res_hi=opa, res_lo=16'hFFFF. Otherwise -> RUN.
- RUN: one iteration per cycle, count 0..15; after iteration 15 -> DONE.
- DONE: done=1 for exactly one cycle; res_hi/res_lo/err loaded on entry to DONE; -> IDLE. busy=0 in DONE, so start in DONE is accepted (next op begins; state -> RUN).
- Multiply (working regs PH=0, PL=opb, M=opa): alu_oper=0000, alu_a=PH, alu_b = PL[0] ? M : 0. Update PH <= {alu_co, alu_result[15:1]}, PL <= {alu_result[0], PL[15:1]}. Final res_hi=PH, res_lo=PL.
- Divide (R=0, Q=opa, D=opb): alu_oper=0001, alu_a={R[14:0], Q[15]}, alu_b=D. ge = R[15] | alu_co. If ge: R <= alu_result, Q <= {Q[14:0],1}; else R <= alu_a, Q <= {Q[14:0],0}. Final res_hi=R, res_lo=Q.
- R[15] term covers the 17-bit partial remainder when D > 16'h8000; the 16-bit alu_result is then exact.
- Outside RUN: alu_a=0, alu_b=0, alu_oper=4'b0000.
- start while busy=1 ignored; opa/opb/op changes during RUN ignored.
- Results hold their value from DONE until the next completion; err cleared when a new start is accepted.

## Timing
- Reset (rst_n=0, immediate): state IDLE, busy=0, done=0, err=0, res_hi=0, res_lo=0, alu_a=0, alu_b=0, alu_oper=0, internal regs 0.
- Reset mid-operation abandons the operation; no done pulse; outputs take reset values.
- Latency: start high in cycle 0 -> RUN cycles 1..16 -> done high in cycle 17. Divide-by-zero: done high in cycle 1.
- Back-to-back: start in the done cycle -> next done 17 cycles later; throughput one op per 17 cycles.
- ALU path is combinational within a cycle; alu_result/alu_co sampled on the same rising edge that advances the iteration.

## Test plan
- MUL opa=16'h1234, opb=16'h5678 -> done in cycle 17, res_hi=16'h0626, res_lo=16'h0060, err=0; busy high exactly cycles 1..16.
- MUL 16'hFFFF x 16'hFFFF -> res_hi=16'hFFFE, res_lo=16'h0001 (exercises alu_co every iteration).
- DIV 16'hFFFF / 16'h0007 -> res_lo=16'h2492, res_hi=16'h0001; DIV 16'hFFFF / 16'h8001 -> res_lo=16'h0001, res_hi=16'h7FFE (R[15] path).
- DIV opa=16'h00AB, opb=0 -> done in cycle 1, err=1, res_hi=16'h00AB, res_lo=16'hFFFF; alu_oper stays 0000.
- start pulsed in cycle 5 of a running MUL with different operands -> ignored, original result delivered in cycle 17; start asserted in the done cycle -> accepted, second result correct 17 cycles later.
- rst_n low in cycle 8 of a DIV -> busy, done, err, res_hi, res_lo immediately 0; no done pulse; fresh MUL 3 x 5 afterward -> res_lo=16'h000F, res_hi=0.
